// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single vga_adapter plot port: one sprite engine per burst,
// registered pixel forwarding, and a watchdog that revokes a grant from a hung engine.
module vga_plot_arbiter #(
  parameter int N_REQ   = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     done,
  input  logic [N_REQ*X_W-1:0] req_x,
  input  logic [N_REQ*Y_W-1:0] req_y,
  input  logic [N_REQ*C_W-1:0] req_colour,
  input  logic [N_REQ-1:0]     req_plot,
  output logic [N_REQ-1:0]     gnt,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic [C_W-1:0]       colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]      state;
  logic [PW-1:0]   ptr, own, win, ptr_nxt;
  logic [WD_W-1:0] wd;
  logic            found;
  logic [PW:0]     idx;
  logic            rel_done, rel_abort, rel_to, rel;

  // First requester at or after ptr, wrapping; the ptr rotation makes this fair.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  assign rel_done  = done[own];
  assign rel_abort = !req[own];
  assign rel_to    = (wd == WD_W'(TIMEOUT-1));
  assign rel       = rel_done | rel_abort | rel_to;
  assign ptr_nxt   = (own == PW'(N_REQ-1)) ? '0 : own + PW'(1);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      own         <= '0;
      wd          <= '0;
      gnt         <= '0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          plot <= 1'b0;
          if (found) begin
            gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            own   <= win;
            wd    <= '0;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (rel) begin
            // The pixel sampled on the release cycle is dropped on purpose.
            gnt         <= '0;
            plot        <= 1'b0;
            ptr         <= ptr_nxt;
            state       <= S_GAP;
            timeout_err <= rel_to & !rel_done & !rel_abort;
          end else begin
            plot <= req_plot[own];
            if (req_plot[own]) begin
              x      <= req_x[int'(own)*X_W +: X_W];
              y      <= req_y[int'(own)*Y_W +: Y_W];
              colour <= req_colour[int'(own)*C_W +: C_W];
            end
            wd <= wd + WD_W'(1);
          end
        end
        S_GAP: begin
          plot  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          gnt   <= '0;
          plot  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
